// File: rtl/bq_pkg.sv
// Shared definitions for the branch update queue.
//   BQ_DEPTH       : default number of in-flight branch entries
//   NO_UPDATE_ADDR : predictor-update address meaning "no update this cycle"
//   bq_entry_t     : one queued branch {PC, predicted direction}
//   bq_err_e       : cause of a protocol error (the output flag is sticky)
package bq_pkg;

    localparam int unsigned BQ_DEPTH       = 8;
    localparam logic [31:0] NO_UPDATE_ADDR = 32'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic        taken;
    } bq_entry_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,  // push while full with no same-cycle pop
        ERR_UNDERFLOW = 2'd2,  // resolve while empty
        ERR_NULL_ADDR = 2'd3   // push of the reserved address 0
    } bq_err_e;

endpackage

// File: rtl/bq_fifo.sv
// Parameterised circular buffer of bq_entry_t.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, pop  : pre-qualified enables (caller guarantees no overflow/underflow)
//   flush      : discard all entries at the next edge (a same-cycle pop still reads)
//   wr_entry   : entry written on push
//   head       : oldest entry (combinational read at rd_ptr)
//   count      : number of valid entries, registered
module bq_fifo
    import bq_pkg::*;
#(
    parameter int unsigned DEPTH = BQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  bq_entry_t        wr_entry,
    output bq_entry_t        head,
    output logic [PTR_W:0]   count
);

    bq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/branch_update_queue.sv
// Tracks in-flight predicted branches and produces the predictor update stream.
// Ports:
//   CLK, RESET                  : clock, asynchronous active-low reset
//   Pred_valid/addr/taken       : fetch pushes a predicted conditional branch
//   Resolve_valid/taken         : execute resolves the oldest branch (in order)
//   Flush                       : squash all outstanding entries
//   Branch_resolved(_addr)      : registered update pulse; addr 0 = no update
//   Mispredict                  : registered one-cycle mispredict pulse
//   Full, Empty, Count          : occupancy, from the registered count
//   Mispredict_count            : saturating mispredict total
//   Error                       : sticky protocol error flag
module branch_update_queue
    import bq_pkg::*;
#(
    parameter int unsigned DEPTH = BQ_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Pred_valid,
    input  logic [31:0]      Pred_addr,
    input  logic             Pred_taken,
    input  logic             Resolve_valid,
    input  logic             Resolve_taken,
    input  logic             Flush,
    output logic             Branch_resolved,
    output logic [31:0]      Branch_resolved_addr,
    output logic             Mispredict,
    output logic             Full,
    output logic             Empty,
    output logic [PTR_W:0]   Count,
    output logic [31:0]      Mispredict_count,
    output logic             Error
);

    bq_entry_t      head;
    bq_entry_t      wr_entry;
    logic [PTR_W:0] count;
    logic           do_push, do_pop;
    bq_err_e        err_cause;

    logic           br_taken_q, br_taken_d;
    logic [31:0]    br_addr_q, br_addr_d;
    logic           mispredict_q, mispredict_d;
    logic [31:0]    mp_count_q, mp_count_d;
    logic           error_q, error_d;

    assign Full  = (count == (PTR_W+1)'(DEPTH));
    assign Empty = (count == '0);

    assign wr_entry = '{addr: Pred_addr, taken: Pred_taken};

    // A resolve never bypasses to a same-cycle push: pop depends only on
    // the registered occupancy.
    assign do_pop  = Resolve_valid && !Empty;
    assign do_push = Pred_valid && !Flush && (Pred_addr != NO_UPDATE_ADDR)
                     && (!Full || do_pop);

    bq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk      (CLK),
        .rst_n    (RESET),
        .push     (do_push),
        .pop      (do_pop),
        .flush    (Flush),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    // A push squashed by Flush is not an error.
    always_comb begin
        err_cause = ERR_NONE;
        if (Resolve_valid && Empty)
            err_cause = ERR_UNDERFLOW;
        else if (Pred_valid && !Flush && Pred_addr == NO_UPDATE_ADDR)
            err_cause = ERR_NULL_ADDR;
        else if (Pred_valid && !Flush && Full && !do_pop)
            err_cause = ERR_OVERFLOW;
    end

    always_comb begin
        br_addr_d    = do_pop ? head.addr : NO_UPDATE_ADDR;
        br_taken_d   = do_pop && Resolve_taken;
        mispredict_d = do_pop && (head.taken != Resolve_taken);
        mp_count_d   = mp_count_q;
        if (mispredict_d && mp_count_q != '1) mp_count_d = mp_count_q + 32'd1;
        error_d      = error_q || (err_cause != ERR_NONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            br_taken_q   <= 1'b0;
            br_addr_q    <= '0;
            mispredict_q <= 1'b0;
            mp_count_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            br_taken_q   <= br_taken_d;
            br_addr_q    <= br_addr_d;
            mispredict_q <= mispredict_d;
            mp_count_q   <= mp_count_d;
            error_q      <= error_d;
        end
    end

    assign Branch_resolved      = br_taken_q;
    assign Branch_resolved_addr = br_addr_q;
    assign Mispredict           = mispredict_q;
    assign Mispredict_count     = mp_count_q;
    assign Error                = error_q;
    assign Count                = count;

endmodule

// File: tb/tb_branch_update_queue.sv
module tb_branch_update_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = 3;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             Pred_valid = 1'b0;
    logic [31:0]      Pred_addr = '0;
    logic             Pred_taken = 1'b0;
    logic             Resolve_valid = 1'b0;
    logic             Resolve_taken = 1'b0;
    logic             Flush = 1'b0;
    logic             Branch_resolved;
    logic [31:0]      Branch_resolved_addr;
    logic             Mispredict;
    logic             Full;
    logic             Empty;
    logic [PTR_W:0]   Count;
    logic [31:0]      Mispredict_count;
    logic             Error;

    branch_update_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Pred_valid           (Pred_valid),
        .Pred_addr            (Pred_addr),
        .Pred_taken           (Pred_taken),
        .Resolve_valid        (Resolve_valid),
        .Resolve_taken        (Resolve_taken),
        .Flush                (Flush),
        .Branch_resolved      (Branch_resolved),
        .Branch_resolved_addr (Branch_resolved_addr),
        .Mispredict           (Mispredict),
        .Full                 (Full),
        .Empty                (Empty),
        .Count                (Count),
        .Mispredict_count     (Mispredict_count),
        .Error                (Error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        pv;
        logic [31:0] pa;
        logic        pt;
        logic        rv;
        logic        rt;
        logic        fl;
        logic [31:0] e_addr;
        logic        e_taken;
        logic        e_mis;
        logic [3:0]  e_count;
        logic        e_err;
        logic [31:0] e_mcnt;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        taken;
    } ent_t;

    vec_t        vecs [9];
    ent_t        q [$];
    logic [31:0] m_mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic pv, input logic [31:0] pa, input logic pt,
                        input logic rv, input logic rt, input logic fl);
        @(negedge CLK);
        Pred_valid    = pv;
        Pred_addr     = pa;
        Pred_taken    = pt;
        Resolve_valid = rv;
        Resolve_taken = rt;
        Flush         = fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Pred_valid = 1'b0; Pred_addr = '0; Pred_taken = 1'b0;
        Resolve_valid = 1'b0; Resolve_taken = 1'b0; Flush = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        q.delete();
        m_mcnt = 32'd0;
    endtask

    // Queue-model step: expected update from the oldest modelled entry.
    task automatic mstep(input logic pv, input logic [31:0] pa, input logic pt,
                         input logic rv, input logic rt, input string tag);
        logic [31:0] ea;
        logic        et;
        logic        em;
        ent_t        h;
        ea = 32'h0; et = 1'b0; em = 1'b0;
        if (rv && q.size() > 0) begin
            h  = q.pop_front();
            ea = h.addr;
            et = rt;
            em = (h.taken != rt);
            if (em && m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
        end
        if (pv && q.size() < int'(DEPTH)) begin
            h.addr  = pa;
            h.taken = pt;
            q.push_back(h);
        end
        step(pv, pa, pt, rv, rt, 1'b0);
        chk({tag, "_addr"},  Branch_resolved_addr, ea);
        chk({tag, "_taken"}, 32'(Branch_resolved), 32'(et));
        chk({tag, "_mis"},   32'(Mispredict), 32'(em));
        chk({tag, "_count"}, 32'(Count), 32'(q.size()));
        chk({tag, "_mcnt"},  Mispredict_count, m_mcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 4'd1, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 4'd2, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0010, 1'b1, 1'b0, 4'd1, 1'b0, 32'd0};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0040_0020, 1'b1, 1'b1, 4'd0, 1'b0, 32'd1};
        vecs[4] = '{1'b1, 32'h0040_0030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 4'd1, 1'b0, 32'd1};
        vecs[5] = '{1'b1, 32'h0040_0040, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0040_0030, 1'b0, 1'b0, 4'd1, 1'b0, 32'd1};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0040, 1'b0, 1'b1, 4'd0, 1'b0, 32'd2};
        vecs[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 1'b0, 4'd0, 1'b0, 32'd2};
        vecs[8] = '{1'b1, 32'h0040_0050, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,          1'b0, 1'b0, 4'd0, 1'b0, 32'd2};

        // Reset state
        RESET = 1'b1;
        #2 RESET = 1'b0;
        #1;
        chk("rst_addr",  Branch_resolved_addr, 32'h0);
        chk("rst_taken", 32'(Branch_resolved), 32'd0);
        chk("rst_mis",   32'(Mispredict), 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_full",  32'(Full), 32'd0);
        chk("rst_err",   32'(Error), 32'd0);
        chk("rst_mcnt",  Mispredict_count, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Table-driven basic sequence
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].pv, vecs[i].pa, vecs[i].pt, vecs[i].rv, vecs[i].rt, vecs[i].fl);
            chk($sformatf("v%0d_addr", i),  Branch_resolved_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_taken", i), 32'(Branch_resolved), 32'(vecs[i].e_taken));
            chk($sformatf("v%0d_mis", i),   32'(Mispredict), 32'(vecs[i].e_mis));
            chk($sformatf("v%0d_count", i), 32'(Count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d_err", i),   32'(Error), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_mcnt", i),  Mispredict_count, vecs[i].e_mcnt);
        end
        chk("tbl_empty", 32'(Empty), 32'd1);
        m_mcnt = 32'd2;

        // Wrap-around: 20 entries, 5 deep, streamed through
        for (int i = 0; i < 5; i++)
            mstep(1'b1, 32'h0050_0000 + 32'(i * 16), i[0], 1'b0, 1'b0, $sformatf("wrp%0d", i));
        for (int i = 5; i < 20; i++)
            mstep(1'b1, 32'h0050_0000 + 32'(i * 16), i[0], 1'b1, (i % 3) == 0, $sformatf("wrs%0d", i));
        for (int i = 0; i < 5; i++)
            mstep(1'b0, 32'h0, 1'b0, 1'b1, i[1], $sformatf("wrd%0d", i));
        chk("wrap_empty", 32'(Empty), 32'd1);
        chk("wrap_err",   32'(Error), 32'd0);

        // Full, overflow drop, push with pop while full
        for (int i = 0; i < 8; i++)
            mstep(1'b1, 32'h0060_0000 + 32'(i * 4), i[1], 1'b0, 1'b0, $sformatf("fp%0d", i));
        chk("full_set",     32'(Full), 32'd1);
        chk("full_err0",    32'(Error), 32'd0);
        mstep(1'b1, 32'h0060_0100, 1'b1, 1'b0, 1'b0, "ovf");
        chk("ovf_err",      32'(Error), 32'd1);
        chk("ovf_full",     32'(Full), 32'd1);
        mstep(1'b1, 32'h0060_0200, 1'b0, 1'b1, 1'b0, "fullpp");
        chk("fullpp_full",  32'(Full), 32'd1);
        for (int i = 0; i < 8; i++)
            mstep(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, $sformatf("fd%0d", i));
        chk("fd_empty",     32'(Empty), 32'd1);

        // Push of reserved address 0
        do_reset();
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("null_count", 32'(Count), 32'd0);
        chk("null_err",   32'(Error), 32'd1);

        // Flush with same-cycle resolve and push
        do_reset();
        step(1'b1, 32'h0040_0110, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0040_0120, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0040_0130, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fl_pre_count", 32'(Count), 32'd3);
        step(1'b1, 32'h0040_0140, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("fl_addr",  Branch_resolved_addr, 32'h0040_0110);
        chk("fl_taken", 32'(Branch_resolved), 32'd0);
        chk("fl_mis",   32'(Mispredict), 32'd1);
        chk("fl_count", 32'(Count), 32'd0);
        chk("fl_err",   32'(Error), 32'd0);
        step(1'b1, 32'h0040_0150, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fl_post_count", 32'(Count), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fl_post_addr", Branch_resolved_addr, 32'h0040_0150);
        chk("fl_post_mis",  32'(Mispredict), 32'd0);
        chk("fl_post_mcnt", Mispredict_count, 32'd1);

        // Resolve while empty with same-cycle push: no bypass
        step(1'b1, 32'h0040_0100, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("emp_addr",  Branch_resolved_addr, 32'h0);
        chk("emp_err",   32'(Error), 32'd1);
        chk("emp_count", 32'(Count), 32'd1);
        chk("emp_empty", 32'(Empty), 32'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h0070_0000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("ar_pre_addr",  Branch_resolved_addr, 32'h0040_0100);
        chk("ar_pre_count", 32'(Count), 32'd5);
        chk("ar_pre_mcnt",  Mispredict_count, 32'd2);
        #2 RESET = 1'b0;
        #1;
        chk("ar_addr",  Branch_resolved_addr, 32'h0);
        chk("ar_taken", 32'(Branch_resolved), 32'd0);
        chk("ar_mis",   32'(Mispredict), 32'd0);
        chk("ar_count", 32'(Count), 32'd0);
        chk("ar_empty", 32'(Empty), 32'd1);
        chk("ar_full",  32'(Full), 32'd0);
        chk("ar_err",   32'(Error), 32'd0);
        chk("ar_mcnt",  Mispredict_count, 32'd0);
        @(negedge CLK);
        Resolve_valid = 1'b0;
        RESET = 1'b1;
        idle();
        chk("ar_post_addr", Branch_resolved_addr, 32'h0);
        chk("ar_post_count", 32'(Count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
